// File: rtl/right_rotate_sequencer.sv
// right_rotate_sequencer
// Accepts a value, a rotate amount and a direction. Then rotates the value one bit
// per clock until the amount is used up, and holds the result until the
// consumer takes it.
module right_rotate_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_dir,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir;

  // Single-bit rotations of the working register in both directions.
  logic [WIDTH-1:0] w_rot_right;
  logic [WIDTH-1:0] w_rot_left;

  // The rotations are bit permutations only. Each output bit takes one neighbour
  // of the register, and the index wraps at the ends.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
    assign w_rot_right[gi] = r_data[(gi + 1) % WIDTH];
    assign w_rot_left[gi]  = r_data[(gi + WIDTH - 1) % WIDTH];
  end

  // Sequencer: load on handshake, rotate once per cycle, then hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_data  <= cmd_data;
            r_cnt   <= cmd_amt;
            r_dir   <= cmd_dir;
            // A zero amount skips rotation and presents the operand as it is.
            r_state <= (cmd_amt == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_data <= r_dir ? w_rot_left : w_rot_right;
          r_cnt  <= r_cnt - AMT_W'(1);
          // The last rotation happens on this edge, so the result is ready next cycle.
          if (r_cnt == AMT_W'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The handshake flags and busy are decoded from the state only. res_data
  // exposes the working register at all times.
  assign cmd_ready = (r_state == S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign res_data  = r_data;

endmodule

// File: tb/tb_right_rotate_sequencer.sv
// Bench for right_rotate_sequencer: directed vector table, random commands
// checked against an arithmetic rotate model, plus reset corner sequences.
module tb_right_rotate_sequencer;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [AMT_W-1:0] cmd_amt;
  logic             cmd_dir;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  right_rotate_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_amt   (cmd_amt),
    .cmd_dir   (cmd_dir),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [7:0] exp;
    int         hold;
  } vec_t;

  vec_t vecs[7];

  // The rotate model works on a doubled copy of the value and takes a window of it.
  function automatic logic [7:0] model_rot(input logic [7:0] d, input int k, input logic dir);
    logic [15:0] dd;
    int          sh;
    dd = {d, d};
    sh = dir ? (WIDTH - k) % WIDTH : k;
    return 8'(dd >> sh);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The caller is at a negedge with the DUT in IDLE. This runs one full command and hands back at a negedge in IDLE.
  task automatic run_cmd(input logic [7:0] d, input logic [2:0] a, input logic dir,
                         input logic [7:0] exp, input int hold);
    int lat;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_amt   = a;
    cmd_dir   = dir;
    @(negedge clk);
    lat = 1;
    while (!res_valid && lat < 40) begin
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_cmd_ready", 32'(cmd_ready), 32'd0);
      // The command inputs and res_ready change here. The DUT must ignore them while busy.
      cmd_valid = 1'($urandom);
      cmd_data  = 8'($urandom);
      cmd_amt   = 3'($urandom);
      cmd_dir   = 1'($urandom);
      res_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    res_ready = 1'b0;
    check("res_valid_seen", 32'(res_valid), 32'd1);
    check("latency", 32'(lat), 32'(1 + int'(a)));
    check("done_busy", 32'(busy), 32'd1);
    check("res_data", 32'(res_data), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      // A new command is offered while the result is not yet consumed.
      cmd_valid = 1'b1;
      cmd_data  = 8'($urandom);
      cmd_amt   = 3'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'(exp));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    check("back_idle_ready", 32'(cmd_ready), 32'd1);
    check("back_idle_busy", 32'(busy), 32'd0);
    check("back_idle_valid", 32'(res_valid), 32'd0);
    $display("cmd data=0x%02h amt=%0d dir=%0d -> res=0x%02h latency=%0d hold=%0d",
             d, a, dir, exp, lat, hold);
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] ra;
    logic       rdir;

    vecs[0] = '{8'h0F, 3'd3, 1'b0, 8'hE1, 1};
    vecs[1] = '{8'hF0, 3'd1, 1'b1, 8'hE1, 0};
    vecs[2] = '{8'hA5, 3'd0, 1'b0, 8'hA5, 2};
    vecs[3] = '{8'h01, 3'd7, 1'b0, 8'h02, 0};
    vecs[4] = '{8'h80, 3'd7, 1'b1, 8'h40, 5};
    vecs[5] = '{8'h5A, 3'd4, 1'b0, 8'hA5, 3};
    vecs[6] = '{8'h3C, 3'd0, 1'b1, 8'h3C, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_amt = '0; cmd_dir = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    $display("reset released: cmd_ready=%0d res_valid=%0d busy=%0d res_data=0x%02h",
             cmd_ready, res_valid, busy, res_data);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].exp, vecs[i].hold);
    end

    // Reset in SHIFT aborts the command, and no result may follow.
    cmd_valid = 1'b1; cmd_data = 8'hC3; cmd_amt = 3'd5; cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_res_data", 32'(res_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("abort_no_result", 32'(res_valid), 32'd0);
    end
    $display("abort in SHIFT: state back to idle, no result");

    // Reset wins over a handshake offered on the same edge.
    cmd_valid = 1'b1; cmd_data = 8'h77; cmd_amt = 3'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_data", 32'(res_data), 32'd0);
    $display("reset with cmd on same edge: command dropped");

    // Reset while in DONE also drops the pending result.
    cmd_valid = 1'b1; cmd_data = 8'h12; cmd_amt = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("done_rst_pre_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("done_rst_valid", 32'(res_valid), 32'd0);
    check("done_rst_data", 32'(res_data), 32'd0);
    $display("reset in DONE: result dropped");

    for (int i = 0; i < 40; i++) begin
      rd   = 8'($urandom);
      ra   = 3'($urandom_range(0, 7));
      rdir = 1'($urandom);
      run_cmd(rd, ra, rdir, model_rot(rd, int'(ra), rdir), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/right_rotate_sequencer.md
RIGHT_ROTATE_SEQUENCER -- requirements
Module: right_rotate_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, data width of the rotate register in bits.
REQ-002 Parameter AMT_W, default 3, width of the rotate-amount field, equal to $clog2(WIDTH).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_data  input  WIDTH  value to rotate.
REQ-009 cmd_amt  input  AMT_W  number of single-bit rotations, 0..WIDTH-1.
REQ-010 cmd_dir  input  1  0 = rotate right, 1 = rotate left.
REQ-011 res_valid  output  1  result present.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_data  output  WIDTH  rotated value.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, SHIFT and DONE, held in a registered state variable.
REQ-016 cmd_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in DONE; both are decoded directly from state.
REQ-017 A command SHALL be accepted on an edge where cmd_valid=1 and cmd_ready=1; that edge loads the register with cmd_data, the counter with cmd_amt and the direction flag with cmd_dir.
REQ-018 On acceptance, next state SHALL be DONE if cmd_amt=0, otherwise SHIFT.
REQ-019 In SHIFT, each edge SHALL perform exactly one single-bit rotation and decrement the counter by 1.
REQ-020 Right rotation: reg <= {reg[0], reg[WIDTH-1:1]}. Left rotation: reg <= {reg[WIDTH-2:0], reg[WIDTH-1]}.
REQ-021 The edge performing the rotation with counter=1 SHALL move the state to DONE.
REQ-022 Latency: if the handshake occurs in cycle c, res_valid SHALL be high from cycle c+1+cmd_amt.
REQ-023 In DONE, res_data and res_valid SHALL be held stable until an edge with res_ready=1, which returns the state to IDLE.
REQ-024 res_data SHALL always equal the rotate register; its value outside DONE is informational only.
REQ-025 cmd_valid, cmd_data, cmd_amt and cmd_dir SHALL be ignored outside IDLE; changes to them SHALL not affect a command in progress.
REQ-026 res_ready SHALL be ignored outside DONE.
REQ-027 No overlap: a new command SHALL be accepted no earlier than the cycle after the DONE->IDLE edge.
REQ-028 Net rotation SHALL equal cmd_amt positions; right rotation by k SHALL equal left rotation by WIDTH-k.

Reset
REQ-029 On an edge with rst=1, the block SHALL set the state to IDLE and clear the register, counter and direction flag to 0, regardless of state.
REQ-030 After reset: cmd_ready=1, res_valid=0, busy=0, res_data=0.
REQ-031 rst SHALL take priority over any handshake on the same edge; a command offered on that edge is dropped.
REQ-032 A reset in SHIFT or DONE SHALL abort the operation; no res_valid is produced for the aborted command.

Verification
REQ-033 Reset, then cmd_data=0x0F, cmd_amt=3, cmd_dir=0, handshake in cycle c -> res_valid rises in cycle c+4 with res_data=0xE1; busy=1 in cycles c+1..c+4.
REQ-034 cmd_data=0xF0, cmd_amt=1, cmd_dir=1 -> res_data=0xE1 in cycle c+2.
REQ-035 cmd_data=0xA5, cmd_amt=0 -> res_valid=1 in cycle c+1 with res_data=0xA5; no SHIFT cycle.
REQ-036 cmd_data=0x01, cmd_amt=7, cmd_dir=0 -> res_data=0x02 in cycle c+8, equal to a left rotation by 1.
REQ-037 Backpressure: hold res_ready=0 for 5 cycles in DONE while driving cmd_valid=1 with new data -> res_data stable, cmd_ready=0, and the new command is not accepted until the cycle after res_ready=1.
REQ-038 Assert rst for one cycle during SHIFT of a cmd_amt=5 command -> next cycle state is IDLE, cmd_ready=1, res_valid=0, res_data=0, and no result appears afterwards.
